// File: rtl/axi_ram_arbiter.sv
// axi_ram_arbiter: round-robin arbiter sharing one word-addressed RAM between two requesters
module axi_ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                  AXI_RAM_ARB_Clk,
    input  logic                  AXI_RAM_ARB_Reset_InLow,
    input  logic                  AXI_RAM_ARB_Req0_Valid,
    input  logic                  AXI_RAM_ARB_Req0_Write,
    input  logic [ADDR_WIDTH-1:0] AXI_RAM_ARB_Req0_Addr,
    input  logic [31:0]           AXI_RAM_ARB_Req0_WData,
    output logic                  AXI_RAM_ARB_Req0_Ready,
    output logic                  AXI_RAM_ARB_Req0_Resp_Valid,
    input  logic                  AXI_RAM_ARB_Req1_Valid,
    input  logic                  AXI_RAM_ARB_Req1_Write,
    input  logic [ADDR_WIDTH-1:0] AXI_RAM_ARB_Req1_Addr,
    input  logic [31:0]           AXI_RAM_ARB_Req1_WData,
    output logic                  AXI_RAM_ARB_Req1_Ready,
    output logic                  AXI_RAM_ARB_Req1_Resp_Valid,
    output logic [31:0]           AXI_RAM_ARB_Resp_RData,
    output logic                  AXI_RAM_ARB_Resp_Err,
    output logic                  AXI_RAM_ARB_Busy,
    output logic                  AXI_RAM_ARB_Ram_Read_Ready,
    output logic                  AXI_RAM_ARB_Ram_Write_Valid,
    output logic [ADDR_WIDTH-1:0] AXI_RAM_ARB_Ram_Address,
    output logic [31:0]           AXI_RAM_ARB_Ram_Data_In,
    input  logic                  AXI_RAM_ARB_Ram_Read_Valid,
    input  logic                  AXI_RAM_ARB_Ram_Write_Ready,
    input  logic [31:0]           AXI_RAM_ARB_Ram_Data_Out
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    localparam logic [3:0] TO = 4'(TIMEOUT);
    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d, lvld_q, lvld_d, gid_q, gid_d, wr_q, wr_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]            cnt_q, cnt_d, cnt_inc;
    logic                  gnt, hs, rdy0, rdy1;

    // Under contention the requester not served last wins; before any completion requester 0 wins
    assign gnt     = (AXI_RAM_ARB_Req0_Valid & AXI_RAM_ARB_Req1_Valid) ? (lvld_q & ~ptr_q) : AXI_RAM_ARB_Req1_Valid;
    assign hs      = wr_q ? AXI_RAM_ARB_Ram_Write_Ready : AXI_RAM_ARB_Ram_Read_Valid;
    assign cnt_inc = cnt_q + 4'd1;

    // State, latched request and response registers
    always_ff @(posedge AXI_RAM_ARB_Clk or negedge AXI_RAM_ARB_Reset_InLow) begin
        if (!AXI_RAM_ARB_Reset_InLow) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            lvld_q  <= 1'b0;
            gid_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lvld_q  <= lvld_d;
            gid_q   <= gid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: grant in IDLE, wait for the matching RAM handshake or timeout in ISSUE, report in RESP
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lvld_d  = lvld_q;
        gid_d   = gid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        unique case (state_q)
            IDLE: if (AXI_RAM_ARB_Req0_Valid | AXI_RAM_ARB_Req1_Valid) begin
                rdy0    = ~gnt;
                rdy1    = gnt;
                gid_d   = gnt;
                wr_d    = gnt ? AXI_RAM_ARB_Req1_Write : AXI_RAM_ARB_Req0_Write;
                addr_d  = gnt ? AXI_RAM_ARB_Req1_Addr : AXI_RAM_ARB_Req0_Addr;
                wdata_d = gnt ? AXI_RAM_ARB_Req1_WData : AXI_RAM_ARB_Req0_WData;
                cnt_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d = hs ? cnt_q : cnt_inc;
                if (hs || cnt_inc == TO) begin
                    state_d = RESP;
                    err_d   = ~hs;
                    rdata_d = (hs && !wr_q) ? AXI_RAM_ARB_Ram_Data_Out : '0;
                end
            end
            RESP: begin
                ptr_d   = gid_q;
                lvld_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign AXI_RAM_ARB_Req0_Ready      = rdy0 & AXI_RAM_ARB_Reset_InLow;
    assign AXI_RAM_ARB_Req1_Ready      = rdy1 & AXI_RAM_ARB_Reset_InLow;
    assign AXI_RAM_ARB_Req0_Resp_Valid = (state_q == RESP) & ~gid_q;
    assign AXI_RAM_ARB_Req1_Resp_Valid = (state_q == RESP) & gid_q;
    assign AXI_RAM_ARB_Resp_RData      = rdata_q;
    assign AXI_RAM_ARB_Resp_Err        = err_q;
    assign AXI_RAM_ARB_Busy            = state_q != IDLE;
    assign AXI_RAM_ARB_Ram_Read_Ready  = (state_q == ISSUE) & ~wr_q;
    assign AXI_RAM_ARB_Ram_Write_Valid = (state_q == ISSUE) & wr_q;
    assign AXI_RAM_ARB_Ram_Address     = addr_q;
    assign AXI_RAM_ARB_Ram_Data_In     = wdata_q;
endmodule

// File: tb/tb_axi_ram_arbiter.sv
// tb_axi_ram_arbiter: scoreboard bench for the two-port RAM arbiter with a behavioural RAM
module tb_axi_ram_arbiter;
    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
    logic [9:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        r0, r1, rv0, rv1, err, busy, ram_rr, ram_wv;
    logic [31:0] rdata, ram_din;
    logic [9:0]  ram_addr;
    logic        ram_rv = 1'b0, ram_wrdy = 1'b0;
    logic [31:0] ram_dout = '0;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          ram_delay = 0, rcnt = 0;
    bit          spur_rv = 0, spur_wr = 0, ram_hs;
    logic [31:0] ram_mem [int];
    logic [31:0] ref_mem [int];
    logic [31:0] hold = '0;
    exp_t        sbq[$];
    exp_t        mon_e;

    axi_ram_arbiter #(.ADDR_WIDTH(10), .TIMEOUT(15)) dut (
        .AXI_RAM_ARB_Clk(clk),
        .AXI_RAM_ARB_Reset_InLow(rst_n),
        .AXI_RAM_ARB_Req0_Valid(v0),
        .AXI_RAM_ARB_Req0_Write(w0),
        .AXI_RAM_ARB_Req0_Addr(a0),
        .AXI_RAM_ARB_Req0_WData(d0),
        .AXI_RAM_ARB_Req0_Ready(r0),
        .AXI_RAM_ARB_Req0_Resp_Valid(rv0),
        .AXI_RAM_ARB_Req1_Valid(v1),
        .AXI_RAM_ARB_Req1_Write(w1),
        .AXI_RAM_ARB_Req1_Addr(a1),
        .AXI_RAM_ARB_Req1_WData(d1),
        .AXI_RAM_ARB_Req1_Ready(r1),
        .AXI_RAM_ARB_Req1_Resp_Valid(rv1),
        .AXI_RAM_ARB_Resp_RData(rdata),
        .AXI_RAM_ARB_Resp_Err(err),
        .AXI_RAM_ARB_Busy(busy),
        .AXI_RAM_ARB_Ram_Read_Ready(ram_rr),
        .AXI_RAM_ARB_Ram_Write_Valid(ram_wv),
        .AXI_RAM_ARB_Ram_Address(ram_addr),
        .AXI_RAM_ARB_Ram_Data_In(ram_din),
        .AXI_RAM_ARB_Ram_Read_Valid(ram_rv),
        .AXI_RAM_ARB_Ram_Write_Ready(ram_wrdy),
        .AXI_RAM_ARB_Ram_Data_Out(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] ref_rd(input logic [9:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (32'hA500_0000 | 32'(a));
    endfunction

    function automatic logic [31:0] ram_rd(input logic [9:0] a);
        return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : (32'hA500_0000 | 32'(a));
    endfunction

    // Behavioural RAM: answers the strobe after ram_delay cycles; spur_* inject unsolicited responses
    always @(posedge clk) begin
        #2;
        ram_hs = 0;
        if (ram_rr || ram_wv) begin
            ram_hs = (rcnt == ram_delay);
            rcnt   = ram_hs ? 0 : rcnt + 1;
        end else begin
            rcnt = 0;
        end
        if (ram_hs && ram_wv) ram_mem[int'(ram_addr)] = ram_din;
        ram_rv   = (ram_hs && ram_rr) || spur_rv;
        ram_wrdy = (ram_hs && ram_wv) || spur_wr;
        ram_dout = spur_rv ? 32'hDEAD_BEEF : (ram_hs && ram_rr) ? ram_rd(ram_addr) : 32'h0;
    end

    // Response scoreboard and per-cycle invariants
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_chk++;
            if (ram_rr && ram_wv) begin
                n_fail++;
                $display("FAIL strobes_exclusive: rr=%b wv=%b, required not both 1", ram_rr, ram_wv);
            end
            n_chk++;
            if (r0 && r1) begin
                n_fail++;
                $display("FAIL ready_exclusive: r0=%b r1=%b, required not both 1", r0, r1);
            end
            if (rv0 || rv1) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: rv0=%b rv1=%b, required no response", rv0, rv1);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({rv1, rv0} !== (mon_e.id ? 2'b10 : 2'b01) || rdata !== mon_e.rdata || err !== mon_e.err) begin
                        n_fail++;
                        $display("FAIL resp_scoreboard: rv1rv0=%b rdata=%h err=%b, required id=%0d rdata=%h err=%b",
                                 {rv1, rv0}, rdata, err, mon_e.id, mon_e.rdata, mon_e.err);
                    end
                    hold = mon_e.rdata;
                end
            end
        end
    end

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        ok = sbq.size() == 0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        v0 = 1'b1;
        v1 = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_chk++;
        if ({r0, r1, rv0, rv1, err, busy, ram_rr, ram_wv} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000000", {r0, r1, rv0, rv1, err, busy, ram_rr, ram_wv});
        end
        n_chk++;
        if (rdata !== 32'h0 || ram_addr !== 10'h0 || ram_din !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h addr=%h din=%h, required all 0", rdata, ram_addr, ram_din);
        end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({r0, r1, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_held: r0r1busy=%b, required 000", {r0, r1, busy});
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_write();
        bit ok;
        ram_delay = 0;
        @(posedge clk);
        #1 {v0, w0, a0, d0} = {1'b1, 1'b1, 10'h000, 32'h0000_0010};
        @(negedge clk);
        n_chk++;
        if (r0 !== 1'b1 || r1 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_accept: r0=%b r1=%b, required 1 0", r0, r1);
        end
        sbq.push_back('{1'b0, 32'h0, 1'b0});
        ref_mem[0] = 32'h0000_0010;
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ram_wv, ram_rr} !== 2'b10 || ram_addr !== 10'h000 || ram_din !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL write_strobe: wv=%b rr=%b addr=%h din=%h, required 1 0 000 00000010", ram_wv, ram_rr, ram_addr, ram_din);
        end
        @(negedge clk);
        n_chk++;
        if ({rv0, rv1} !== 2'b10 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp_n2: rv0=%b rv1=%b err=%b, required 1 0 0", rv0, rv1, err);
        end
        wait_drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_drain: %0d pending, required 0", sbq.size());
        end
    endtask

    task automatic test_read_delay();
        bit ok;
        ram_delay = 2;
        @(posedge clk);
        #1 {v1, w1, a1} = {1'b1, 1'b0, 10'h000};
        @(negedge clk);
        n_chk++;
        if (r1 !== 1'b1 || r0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_accept: r0=%b r1=%b, required 0 1", r0, r1);
        end
        sbq.push_back('{1'b1, ref_rd(10'h000), 1'b0});
        @(posedge clk);
        #1 v1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (ram_rr !== 1'b1 || rv1 !== 1'b0) begin
                n_fail++;
                $display("FAIL read_wait_n%0d: rr=%b rv1=%b, required 1 0", k, ram_rr, rv1);
            end
        end
        @(negedge clk);
        n_chk++;
        if (rv1 !== 1'b1 || rdata !== 32'h0000_0010 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp_n4: rv1=%b rdata=%h err=%b, required 1 00000010 0", rv1, rdata, err);
        end
        wait_drain(ok);
        ram_delay = 0;
    endtask

    task automatic test_back_to_back();
        int   n = 0, acc[4];
        logic [3:0] seq = '0;
        logic g;
        bit   ok;
        apply_reset();
        ram_delay = 0;
        @(posedge clk);
        #1 {v0, w0, a0, d0, v1, w1, a1} = {1'b1, 1'b1, 10'h005, 32'h0000_0100, 1'b1, 1'b0, 10'h005};
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            g = 1'bx;
            if (r0 || r1) begin
                g = r1;
                seq = {seq[2:0], g};
                acc[n] = cyc;
                n++;
                if (g) begin
                    sbq.push_back('{1'b1, ref_rd(10'h005), 1'b0});
                end else begin
                    sbq.push_back('{1'b0, 32'h0, 1'b0});
                    ref_mem[5] = d0;
                end
            end
            @(posedge clk);
            #1;
            if (n == 4) {v0, v1} = 2'b00;
            else if (g === 1'b0) d0 = d0 + 32'h1;
        end
        n_chk++;
        if (n != 4 || seq !== 4'b0101) begin
            n_fail++;
            $display("FAIL b2b_grants: %0d grants order=%b, required 4 grants 0101", n, seq);
        end
        for (int i = 1; i < 4; i++) begin
            n_chk++;
            if (n == 4 && acc[i] - acc[i-1] != 3) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: %0d cycles, required 3", i, acc[i] - acc[i-1]);
            end
        end
        wait_drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d pending, required 0", sbq.size());
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit ok;
        ram_delay = 1000;
        @(posedge clk);
        #1 {v0, w0, a0} = {1'b1, 1'b0, 10'h3FF};
        @(negedge clk);
        n_chk++;
        if (r0 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_accept: r0=%b, required 1", r0);
        end
        sbq.push_back('{1'b0, 32'h0, 1'b1});
        @(posedge clk);
        #1 v0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ram_rr !== 1'b1) break;
            n++;
        end
        n_chk++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL timeout_strobe_len: %0d cycles, required 15", n);
        end
        n_chk++;
        if (rv0 !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || ram_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_resp: rv0=%b err=%b rdata=%h rr=%b, required 1 1 00000000 0", rv0, err, rdata, ram_rr);
        end
        wait_drain(ok);
        ram_delay = 0;
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        ram_delay = 1000;
        @(posedge clk);
        #1 {v0, w0, a0, d0} = {1'b1, 1'b1, 10'h003, 32'h0000_CAFE};
        @(negedge clk);
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        #2;
        n_chk++;
        if (ram_wv !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: wv=%b busy=%b, required 1 1", ram_wv, busy);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({r0, r1, rv0, rv1, err, busy, ram_rr, ram_wv} !== 8'b0 || rdata !== 32'h0 || ram_addr !== 10'h0 || ram_din !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: flags=%b rdata=%h addr=%h din=%h, required all 0",
                     {r0, r1, rv0, rv1, err, busy, ram_rr, ram_wv}, rdata, ram_addr, ram_din);
        end
        ram_delay = 0;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if ({rv0, rv1, busy} !== 3'b0) begin
                n_fail++;
                $display("FAIL midrst_no_resp: rv0rv1busy=%b, required 000", {rv0, rv1, busy});
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {v0, w0, a0, v1, w1, a1} = {1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000};
        @(negedge clk);
        n_chk++;
        if (r0 !== 1'b1 || r1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_first_grant: r0=%b r1=%b, required 1 0", r0, r1);
        end
        if (r0 === 1'b1) sbq.push_back('{1'b0, ref_rd(10'h000), 1'b0});
        @(posedge clk);
        #1 v0 = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            ok = r1 === 1'b1;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_second_grant: r1 not seen in 10 cycles, required 1");
        end else begin
            sbq.push_back('{1'b1, ref_rd(10'h000), 1'b0});
        end
        @(posedge clk);
        #1 v1 = 1'b0;
        wait_drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_drain: %0d pending, required 0", sbq.size());
        end
    endtask

    task automatic test_spurious();
        bit ok;
        @(posedge clk);
        #1 spur_rv = 1;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || rdata !== hold || err !== 1'b0) begin
                n_fail++;
                $display("FAIL spur_idle: busy=%b rdata=%h err=%b, required 0 %h 0", busy, rdata, err, hold);
            end
        end
        @(posedge clk);
        #1;
        spur_rv = 0;
        spur_wr = 1;
        ram_delay = 4;
        {v0, w0, a0} = {1'b1, 1'b0, 10'h007};
        @(negedge clk);
        n_chk++;
        if (r0 !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_accept: r0=%b, required 1", r0);
        end
        sbq.push_back('{1'b0, ref_rd(10'h007), 1'b0});
        @(posedge clk);
        #1 v0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b1 || ram_rr !== 1'b1 || rv0 !== 1'b0 || rdata !== hold) begin
                n_fail++;
                $display("FAIL spur_wrdy_n%0d: busy=%b rr=%b rv0=%b rdata=%h, required 1 1 0 %h", k, busy, ram_rr, rv0, rdata, hold);
            end
        end
        @(negedge clk);
        n_chk++;
        if (rv0 !== 1'b1 || rdata !== ref_rd(10'h007)) begin
            n_fail++;
            $display("FAIL spur_resp: rv0=%b rdata=%h, required 1 %h", rv0, rdata, ref_rd(10'h007));
        end
        spur_wr = 0;
        ram_delay = 0;
        wait_drain(ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL spur_drain: %0d pending, required 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_delay();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_spurious();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
